// File: rtl/pip_stage_elastic.sv
// pip_stage_elastic
//   Elastic pipeline-stage register with a 2-entry skid buffer. It sits
//   between two pipeline stages. The caller packs the fields into in_data
//   and in_ctrl.
//   The main register M drives the outputs. The skid register S catches the
//   entry that arrives in the cycle after the downstream stage stalls.
//   in_ready comes straight from a flop, so there is no combinational path
//   from out_ready to in_ready.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous squash of every held entry
//   in_valid/in_ready upstream handshake
//   in_data/in_ctrl   upstream payload
//   out_valid/ready   downstream handshake
//   out_data/out_ctrl head payload; out_ctrl reads 0 while out_valid=0
//   occ               number of entries held (0..2)
//   stall_cnt         saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt        saturating count of cycles with ~out_valid
module pip_stage_elastic #(
  parameter int DW    = 16,
  parameter int CW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  // State encoding is {s_v, m_v}, so the valid bits are plain state bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DW-1:0]    m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CW-1:0]    m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  logic m_v, s_v, in_fire, out_fire;

  assign m_v      = state_q[0];
  assign s_v      = state_q[1];
  assign in_ready = ~s_v;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_v & out_ready;

  assign out_valid  = m_v;
  assign out_data   = m_data_q;
  assign out_ctrl   = m_ctrl_q & {CW{m_v}};  // a bubble presents as a NOP
  assign occ        = {1'b0, m_v} + {1'b0, s_v};
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush) begin
      // Flush also discards an entry that is accepted in the same cycle.
      state_d  = ST_EMPTY;
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d  = ST_FULL;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // S holds its stale contents after it drains; s_v is what matters.
          if (out_fire) begin
            state_d  = ST_ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // The counters look at the state before the edge, flush cycles included.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_v && !out_ready && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (!m_v && (bubble_cnt_q != CNT_MAX))
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      m_data_q     <= '0;
      m_ctrl_q     <= '0;
      s_data_q     <= '0;
      s_ctrl_q     <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      m_data_q     <= m_data_d;
      m_ctrl_q     <= m_ctrl_d;
      s_data_q     <= s_data_d;
      s_ctrl_q     <= s_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pip_stage_elastic.sv
// tb_pip_stage_elastic
//   Table-driven check of pip_stage_elastic. Each table row gives the inputs
//   applied before one clock edge and the outputs expected just after that
//   edge. A second instance with 4-bit counters shares the same inputs and
//   is used for the saturation sequence.
module tb_pip_stage_elastic;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [4:0]  in_ctrl;

  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [4:0]  out_ctrl;
  logic [1:0]  occ;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [15:0] sat_out_data;
  logic [4:0]  sat_out_ctrl;
  logic [1:0]  sat_occ;
  logic [3:0]  sat_stall_cnt, sat_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pip_stage_elastic #(.DW(16), .CW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occ(occ), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pip_stage_elastic #(.DW(16), .CW(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_ctrl(sat_out_ctrl), .occ(sat_occ), .stall_cnt(sat_stall_cnt),
    .bubble_cnt(sat_bubble_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [15:0] id;
    logic [4:0]  ic;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [4:0]  e_oc;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [15:0] e_stall;
    logic [15:0] e_bubble;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst flush iv data ctrl ordy | ov od oc occ ir stall bubble
    // Reset held two cycles with input asserted
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 5'b00010, 1'b1, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 5'b00010, 1'b1, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd0, 16'd0};
    // Back-to-back stream, one-cycle latency
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{1'b0, 1'b0, 1'b1, 16'(i+1), 5'b00010, 1'b1, 1'b1, 16'(i+1), 5'b00010, 2'd1, 1'b1, 16'd0, 16'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 16'h0008, 5'b00000, 2'd0, 1'b1, 16'd0, 16'd1};
    // Backpressure: AA, BB fill the stage, CC waits for in_ready
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h00AA, 5'b10001, 1'b0, 1'b1, 16'h00AA, 5'b10001, 2'd1, 1'b1, 16'd0, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h00BB, 5'b10001, 1'b0, 1'b1, 16'h00AA, 5'b10001, 2'd2, 1'b0, 16'd1, 16'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h00CC, 5'b10001, 1'b0, 1'b1, 16'h00AA, 5'b10001, 2'd2, 1'b0, 16'd2, 16'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h00CC, 5'b10001, 1'b0, 1'b1, 16'h00AA, 5'b10001, 2'd2, 1'b0, 16'd3, 16'd2};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h00CC, 5'b10001, 1'b1, 1'b1, 16'h00BB, 5'b10001, 2'd1, 1'b1, 16'd3, 16'd2};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 16'h00CC, 5'b10001, 1'b1, 1'b1, 16'h00CC, 5'b10001, 2'd1, 1'b1, 16'd3, 16'd2};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 16'h00CC, 5'b00000, 2'd0, 1'b1, 16'd3, 16'd2};
    // Flush while FULL with DD offered, then flush in ONE with a real in_fire of DD
    vecs[18] = '{1'b0, 1'b0, 1'b1, 16'h0011, 5'b01100, 1'b0, 1'b1, 16'h0011, 5'b01100, 2'd1, 1'b1, 16'd3, 16'd3};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 16'h0022, 5'b01100, 1'b0, 1'b1, 16'h0011, 5'b01100, 2'd2, 1'b0, 16'd4, 16'd3};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 16'h00DD, 5'b01100, 1'b0, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd5, 16'd3};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd5, 16'd4};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 16'h0033, 5'b01100, 1'b0, 1'b1, 16'h0033, 5'b01100, 2'd1, 1'b1, 16'd5, 16'd5};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 16'h00DD, 5'b01100, 1'b0, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd6, 16'd5};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd6, 16'd6};
    // Reset while FULL with nonzero counters
    vecs[25] = '{1'b0, 1'b0, 1'b1, 16'h0044, 5'b01100, 1'b0, 1'b1, 16'h0044, 5'b01100, 2'd1, 1'b1, 16'd6, 16'd7};
    vecs[26] = '{1'b0, 1'b0, 1'b1, 16'h0055, 5'b01100, 1'b0, 1'b1, 16'h0044, 5'b01100, 2'd2, 1'b0, 16'd7, 16'd7};
    vecs[27] = '{1'b1, 1'b0, 1'b1, 16'h0066, 5'b01100, 1'b0, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd0, 16'd0};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0, 16'h0000, 5'b00000, 2'd0, 1'b1, 16'd0, 16'd1};

    for (int v = 0; v < NV; v++) begin
      rst       = vecs[v].rst;
      flush     = vecs[v].flush;
      in_valid  = vecs[v].iv;
      in_data   = vecs[v].id;
      in_ctrl   = vecs[v].ic;
      out_ready = vecs[v].ordy;
      tick();
      check($sformatf("v%0d out_valid", v),  32'(out_valid),  32'(vecs[v].e_ov));
      check($sformatf("v%0d out_data", v),   32'(out_data),   32'(vecs[v].e_od));
      check($sformatf("v%0d out_ctrl", v),   32'(out_ctrl),   32'(vecs[v].e_oc));
      check($sformatf("v%0d occ", v),        32'(occ),        32'(vecs[v].e_occ));
      check($sformatf("v%0d in_ready", v),   32'(in_ready),   32'(vecs[v].e_ir));
      check($sformatf("v%0d stall_cnt", v),  32'(stall_cnt),  32'(vecs[v].e_stall));
      check($sformatf("v%0d bubble_cnt", v), 32'(bubble_cnt), 32'(vecs[v].e_bubble));
      $display("vec %0d: ov=%0b od=%h oc=%b occ=%0d ir=%0b stall=%0d bubble=%0d",
               v, out_valid, out_data, out_ctrl, occ, in_ready, stall_cnt, bubble_cnt);
    end

    // Saturation: one entry held with out_ready=0 for 20 cycles
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_ctrl = 5'b0; out_ready = 1'b0;
    tick();
    check("sat reset stall", 32'(sat_stall_cnt), 32'd0);
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h0077; in_ctrl = 5'b00001;
    tick();
    check("sat load out_valid", 32'(sat_out_valid), 32'd1);
    check("sat load out_data", 32'(sat_out_data), 32'h0077);
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat stall c%0d", i), 32'(sat_stall_cnt), (i > 15) ? 32'd15 : 32'(i));
      check($sformatf("wide stall c%0d", i), 32'(stall_cnt), 32'(i));
      $display("sat cycle %0d: sat_stall=%0d stall=%0d", i, sat_stall_cnt, stall_cnt);
    end
    check("sat bubble", 32'(sat_bubble_cnt), 32'd1);
    check("sat held data", 32'(sat_out_data), 32'h0077);

    // Drain it; the entry leaves once and the stage is empty afterwards
    out_ready = 1'b1;
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);
    check("drain occ", 32'(occ), 32'd0);
    check("drain stall held", 32'(sat_stall_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
